ysyx_22050243_rf_wr_arb: RTL

- Arbitrates the single GPR write port between in-order writeback (WB) and the long-latency unit (LL: mul/div, uncached loads).
- Buffers LL results in a small FIFO.
- Holds a per-register pending scoreboard so issue stalls on RAW/WAW against in-flight LL destinations.
- Sits between WB/LL result buses and the register file write port; sb_busy feeds the ID-stage hazard logic.

---
 rtl/ysyx_22050243_rf_wr_arb.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22050243_rf_wr_arb.sv
// GPR write-port arbiter: in-order WB vs. long-latency (mul/div, uncached load) results,
// with a small LL result FIFO, a pending-destination scoreboard and a starvation escalator.
module ysyx_22050243_rf_wr_arb #(
    parameter int LL_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_wen,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_wdata,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_rd,
    input  logic [63:0] ll_wdata,
    input  logic        sb_set,
    input  logic [4:0]  sb_set_rd,
    input  logic [4:0]  sb_rs1,
    input  logic [4:0]  sb_rs2,
    input  logic [4:0]  sb_rd,
    output logic        sb_busy,
    output logic        ll_prio_req,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        arb_err,
    output logic        dbg_state
);

    localparam int PTR_W = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX) + 1;

    typedef enum logic {
        ST_NORM = 1'b0,
        ST_PRIO = 1'b1
    } starve_state_t;

    // ------------------------------------------------------------------
    // LL result FIFO
    // ------------------------------------------------------------------
    logic [4:0]       q_rd   [LL_DEPTH];
    logic [63:0]      q_data [LL_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic        empty;
    logic        full;
    logic        wb_win;
    logic        head_pop;
    logic        ll_push;
    logic        bypass;
    logic        fifo_push;
    logic        ll_grant;
    logic [4:0]  grant_rd;
    logic [63:0] grant_data;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(LL_DEPTH));
    // A WB write to x0 never occupies the port.
    assign wb_win = wb_wen && (wb_rd != 5'd0);

    // LL handshake: a result transfers on any cycle with ll_valid && ll_ready.
    // ll_ready is high when a slot is free or the head leaves this same cycle;
    // ll_valid may be held low-ready indefinitely without consequence.
    assign head_pop  = !empty && !wb_win;
    assign ll_ready  = !full || head_pop;
    assign ll_push   = ll_valid && ll_ready;
    assign bypass    = empty && ll_push && !wb_win;
    assign fifo_push = ll_push && !bypass;

    assign ll_grant   = head_pop || bypass;
    assign grant_rd   = head_pop ? q_rd[rd_ptr]   : ll_rd;
    assign grant_data = head_pop ? q_data[rd_ptr] : ll_wdata;

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            q_rd[wr_ptr]   <= ll_rd;
            q_data[wr_ptr] <= ll_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (head_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_push, head_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register-file write port (one-cycle latency from grant)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 64'd0;
        end else if (wb_win) begin
            rf_wen   <= 1'b1;
            rf_waddr <= wb_rd;
            rf_wdata <= wb_wdata;
        end else if (ll_grant) begin
            // An x0 LL entry still spends its grant slot but never writes.
            rf_wen   <= (grant_rd != 5'd0);
            rf_waddr <= grant_rd;
            rf_wdata <= grant_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pending-destination scoreboard
    // ------------------------------------------------------------------
    logic [31:0] pend;
    logic [31:0] pend_next;

    always_comb begin
        pend_next = pend;
        if (ll_grant) begin
            pend_next[grant_rd] = 1'b0;
        end
        // A new producer issued in the retiring cycle keeps the bit set.
        if (sb_set) begin
            pend_next[sb_set_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 32'd0;
        end else begin
            pend <= pend_next;
        end
    end

    assign sb_busy = pend[sb_rs1] | pend[sb_rs2] | pend[sb_rd];

    // ------------------------------------------------------------------
    // Protocol-violation flag (sticky until reset)
    // ------------------------------------------------------------------
    logic sb_dup;
    logic wb_waw;
    logic ll_orphan;
    logic err_set;

    // Re-issuing a destination whose old producer retires this cycle is legal.
    assign sb_dup    = sb_set && pend[sb_set_rd] && !(ll_grant && (grant_rd == sb_set_rd));
    assign wb_waw    = wb_win && pend[wb_rd];
    assign ll_orphan = ll_push && (ll_rd != 5'd0) && !pend[ll_rd];
    assign err_set   = sb_dup || wb_waw || ll_orphan;

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_err <= 1'b0;
        end else if (err_set) begin
            arb_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Starvation FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    starve_state_t    state;
    starve_state_t    state_next;
    logic [SC_W-1:0]  starve_cnt;
    logic [SC_W-1:0]  starve_cnt_next;
    logic             head_blocked;

    assign head_blocked = !empty && wb_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_NORM;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        case (state)
            ST_NORM: begin
                if (head_blocked) begin
                    if (starve_cnt == SC_W'(STARVE_MAX - 1)) begin
                        state_next      = ST_PRIO;
                        starve_cnt_next = '0;
                    end else begin
                        starve_cnt_next = starve_cnt + SC_W'(1);
                    end
                end else begin
                    starve_cnt_next = '0;
                end
            end
            ST_PRIO: begin
                starve_cnt_next = '0;
                if (head_pop) begin
                    state_next = ST_NORM;
                end
            end
            default: begin
                state_next      = ST_NORM;
                starve_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        ll_prio_req = (state == ST_PRIO);
        dbg_state   = state;
    end

endmodule
